// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch definitions: funct3 codes, counter encodings, saturating step.
package branch_predict_resolve_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Saturating 2-bit step; never wraps between ST and SNT.
  function automatic ctr_e ctrNext(input ctr_e c, input logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_e'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch-lookup, execute-resolve and comparator signals of the branch resolver.
interface branch_predict_resolve_if;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic        BrUn;
  logic        BrEq;
  logic        BrLT;
  logic        ex_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_funct3, ex_pred_taken, ex_target, BrEq, BrLT,
    input  fetch_pred_taken, BrUn, ex_taken, mispredict, redirect_pc, br_count, mp_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_funct3, ex_pred_taken, ex_target, BrEq, BrLT,
    output fetch_pred_taken, BrUn, ex_taken, mispredict, redirect_pc, br_count, mp_count
  );
endinterface

// File: rtl/branch_predict_resolve_bht.sv
// Direct-mapped table of 2-bit saturating counters, async read, sync update.
module bht_table
  import branch_predict_resolve_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rdIdx,
  output ctr_e                rdCtr,
  input  logic                updEn,
  input  logic [IDX_BITS-1:0] updIdx,
  input  logic                updTaken
);

  ctr_e tbl [ENTRIES];

  // Reset has priority so a branch resolving under reset leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
    end else if (updEn) begin
      tbl[updIdx] <= ctrNext(tbl[updIdx], updTaken);
    end
  end

  assign rdCtr = tbl[rdIdx];

endmodule

// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolution, mispredict/redirect, BHT training and stats.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_BITS    = 6
) (
  input logic clk,
  input logic rst,
  branch_predict_resolve_if.slave bus
);

  logic        dirTaken;
  logic        f3Valid;
  logic        resolve;
  logic        exTaken;
  logic        mispred;
  ctr_e        predCtr;
  logic [31:0] brCnt;
  logic [31:0] mpCnt;

  always_comb begin
    dirTaken = 1'b0;
    f3Valid  = 1'b1;
    unique case (bus.ex_funct3)
      F3_BEQ:  dirTaken = bus.BrEq;
      F3_BNE:  dirTaken = !bus.BrEq;
      F3_BLT:  dirTaken = bus.BrLT;
      F3_BGE:  dirTaken = !bus.BrLT;
      F3_BLTU: dirTaken = bus.BrLT;
      F3_BGEU: dirTaken = !bus.BrLT;
      default: f3Valid  = 1'b0;
    endcase
  end

  assign resolve = bus.ex_valid & f3Valid;
  assign exTaken = resolve & dirTaken;
  assign mispred = resolve & (exTaken != bus.ex_pred_taken);

  assign bus.BrUn        = bus.ex_funct3[1];
  assign bus.ex_taken    = exTaken;
  assign bus.mispredict  = mispred;
  assign bus.redirect_pc = exTaken ? bus.ex_target : bus.ex_pc + 32'd4;

  bht_table #(.ENTRIES(BHT_ENTRIES), .IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rdIdx    (bus.fetch_pc[IDX_BITS+1:2]),
    .rdCtr    (predCtr),
    .updEn    (resolve),
    .updIdx   (bus.ex_pc[IDX_BITS+1:2]),
    .updTaken (exTaken)
  );

  assign bus.fetch_pred_taken = predCtr[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      brCnt <= '0;
      mpCnt <= '0;
    end else begin
      if (resolve) brCnt <= brCnt + 32'd1;
      if (mispred) mpCnt <= mpCnt + 32'd1;
    end
  end

  assign bus.br_count = brCnt;
  assign bus.mp_count = mpCnt;

  logic unusedBits;
  assign unusedBits = ^{bus.fetch_pc[31:IDX_BITS+2], bus.fetch_pc[1:0], predCtr[0]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Vector table for the directed sequence, then random traffic against a counter-array model.
module tb_branch_predict_resolve;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_resolve_if bus();

  branch_predict_resolve #(.BHT_ENTRIES(64), .IDX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        pt;
    logic [31:0] tgt;
    logic        eq;
    logic        lt;
    logic [31:0] fpc;
    logic        eTaken;
    logic        eMp;
    logic        eFp;
    logic        eBrUn;
    logic [31:0] eRedir;
    logic [31:0] eBr;
    logic [31:0] eMpc;
  } vec_t;

  vec_t vecs[19];

  int          mCtr[64];
  logic [31:0] mBr;
  logic [31:0] mMp;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                              input logic pt, input logic [31:0] tgt, input logic eq,
                              input logic lt, input logic [31:0] fpc, input logic eTaken,
                              input logic eMp, input logic eFp, input logic eBrUn,
                              input logic [31:0] eRedir, input logic [31:0] eBr,
                              input logic [31:0] eMpc);
    vec_t r;
    r.v = v; r.pc = pc; r.f3 = f3; r.pt = pt; r.tgt = tgt; r.eq = eq; r.lt = lt; r.fpc = fpc;
    r.eTaken = eTaken; r.eMp = eMp; r.eFp = eFp; r.eBrUn = eBrUn;
    r.eRedir = eRedir; r.eBr = eBr; r.eMpc = eMpc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                       input logic pt, input logic [31:0] tgt, input logic eq,
                       input logic lt, input logic [31:0] fpc);
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_funct3     = f3;
    bus.ex_pred_taken = pt;
    bus.ex_target     = tgt;
    bus.BrEq          = eq;
    bus.BrLT          = lt;
    bus.fetch_pc      = fpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: branch semantics written straight from the ISA meaning.
  function automatic void mDecide(input logic [2:0] f3, input logic eq, input logic lt,
                                  output bit ok, output bit tk);
    ok = 1'b1;
    tk = 1'b0;
    case (f3)
      3'd0:       tk = eq;
      3'd1:       tk = !eq;
      3'd4, 3'd6: tk = lt;
      3'd5, 3'd7: tk = !lt;
      default:    ok = 1'b0;
    endcase
  endfunction

  function automatic int mIdx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic mReset();
    for (int i = 0; i < 64; i++) mCtr[i] = 1;
    mBr = 0;
    mMp = 0;
  endtask

  initial begin
    vec_t r;
    bit ok, tk, eTk, eMp, doRst;
    logic v, pt, eq, lt;
    logic [2:0] f3;
    logic [31:0] pc, fpc, tgt;
    int k;

    //              v  pc            f3 pt tgt           eq lt fpc            tk mp fp un redir         br  mpc
    vecs[0]  = mk(0, 32'h100,      0, 0, 32'h0,      0, 0, 32'h100,  0, 0, 0, 0, 32'h104,  0,  0);
    vecs[1]  = mk(1, 32'h100,      0, 0, 32'h140,    1, 0, 32'h100,  1, 1, 0, 0, 32'h140,  0,  0);
    vecs[2]  = mk(1, 32'h100,      0, 1, 32'h140,    1, 0, 32'h100,  1, 0, 1, 0, 32'h140,  1,  1);
    vecs[3]  = mk(1, 32'h100,      0, 1, 32'h140,    1, 0, 32'h100,  1, 0, 1, 0, 32'h140,  2,  1);
    vecs[4]  = mk(1, 32'h100,      0, 1, 32'h140,    1, 0, 32'h100,  1, 0, 1, 0, 32'h140,  3,  1);
    vecs[5]  = mk(1, 32'h100,      1, 1, 32'h140,    1, 0, 32'h100,  0, 1, 1, 0, 32'h104,  4,  1);
    vecs[6]  = mk(1, 32'h100,      1, 1, 32'h140,    1, 0, 32'h100,  0, 1, 1, 0, 32'h104,  5,  2);
    vecs[7]  = mk(1, 32'h100,      1, 0, 32'h140,    1, 0, 32'h100,  0, 0, 0, 0, 32'h104,  6,  3);
    vecs[8]  = mk(1, 32'h100,      1, 0, 32'h140,    1, 0, 32'h100,  0, 0, 0, 0, 32'h104,  7,  3);
    vecs[9]  = mk(0, 32'h100,      0, 0, 32'h0,      0, 0, 32'h100,  0, 0, 0, 0, 32'h104,  8,  3);
    vecs[10] = mk(1, 32'h104,      6, 0, 32'h500,    0, 1, 32'h100,  1, 1, 0, 1, 32'h500,  8,  3);
    vecs[11] = mk(1, 32'h108,      4, 0, 32'h600,    0, 0, 32'h100,  0, 0, 0, 0, 32'h10C,  9,  4);
    vecs[12] = mk(1, 32'h10C,      7, 1, 32'h700,    0, 0, 32'h104,  1, 0, 1, 1, 32'h700, 10,  4);
    vecs[13] = mk(1, 32'h100,      2, 1, 32'h800,    1, 1, 32'h10C,  0, 0, 1, 1, 32'h104, 11,  4);
    vecs[14] = mk(1, 32'h100,      3, 0, 32'h800,    1, 1, 32'h100,  0, 0, 0, 1, 32'h104, 11,  4);
    vecs[15] = mk(1, 32'hFFFFFFFC, 0, 1, 32'h40,     0, 0, 32'h100,  0, 1, 0, 0, 32'h0,    11,  4);
    vecs[16] = mk(1, 32'h200,      5, 0, 32'h900,    0, 0, 32'h200,  1, 1, 0, 0, 32'h900, 12,  5);
    vecs[17] = mk(1, 32'h200,      5, 0, 32'h900,    0, 0, 32'h100,  1, 1, 0, 0, 32'h900, 13,  6);
    vecs[18] = mk(0, 32'h200,      0, 0, 32'h0,      0, 0, 32'h100,  0, 0, 1, 0, 32'h204, 14,  7);

    rst = 1'b1;
    drive(0, 32'h0, 3'd0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      r = vecs[i];
      drive(r.v, r.pc, r.f3, r.pt, r.tgt, r.eq, r.lt, r.fpc);
      #1;
      chk($sformatf("row%0d ex_taken", i),    32'(bus.ex_taken),         32'(r.eTaken));
      chk($sformatf("row%0d mispredict", i),  32'(bus.mispredict),       32'(r.eMp));
      chk($sformatf("row%0d fetch_pred", i),  32'(bus.fetch_pred_taken), 32'(r.eFp));
      chk($sformatf("row%0d BrUn", i),        32'(bus.BrUn),             32'(r.eBrUn));
      chk($sformatf("row%0d redirect_pc", i), bus.redirect_pc,           r.eRedir);
      chk($sformatf("row%0d br_count", i),    bus.br_count,              r.eBr);
      chk($sformatf("row%0d mp_count", i),    bus.mp_count,              r.eMpc);
      tick();
    end

    // Reset arriving alongside a valid branch: comb outputs stay live, reset wins the edge.
    rst = 1'b1;
    drive(1, 32'h100, 3'd0, 0, 32'h140, 1, 0, 32'h100);
    #1;
    chk("rstv ex_taken",    32'(bus.ex_taken),         32'd1);
    chk("rstv mispredict",  32'(bus.mispredict),       32'd1);
    chk("rstv redirect_pc", bus.redirect_pc,           32'h140);
    chk("rstv fetch_pred",  32'(bus.fetch_pred_taken), 32'd1);
    tick();
    rst = 1'b0;
    drive(0, 32'h100, 3'd0, 0, 32'h0, 0, 0, 32'h100);
    #1;
    chk("post-rst fetch_pred idx0", 32'(bus.fetch_pred_taken), 32'd0);
    chk("post-rst br_count",        bus.br_count,              32'd0);
    chk("post-rst mp_count",        bus.mp_count,              32'd0);
    bus.fetch_pc = 32'h10C;
    #1;
    chk("post-rst fetch_pred idx3", 32'(bus.fetch_pred_taken), 32'd0);
    // Entry 63 was SNT before reset; one taken step must lift a WNT entry to predict taken.
    drive(1, 32'hFFFFFFFC, 3'd0, 0, 32'h40, 1, 0, 32'hFC);
    tick();
    drive(0, 32'h0, 3'd0, 0, 32'h0, 0, 0, 32'hFC);
    #1;
    chk("post-rst idx63 trained", 32'(bus.fetch_pred_taken), 32'd1);
    chk("post-rst br_count 1",    bus.br_count,              32'd1);
    chk("post-rst mp_count 1",    bus.mp_count,              32'd1);

    // Random traffic over a narrow PC window so aliasing and saturation happen often.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mReset();
    for (int n = 0; n < 600; n++) begin
      doRst = ($urandom_range(0, 59) == 0);
      v     = ($urandom_range(0, 3) != 0);
      f3    = 3'($urandom_range(0, 7));
      pt    = 1'($urandom);
      eq    = 1'($urandom);
      lt    = 1'($urandom);
      tgt   = $urandom;
      pc    = ($urandom_range(0, 1) != 0) ? 32'h0 : ($urandom & 32'hFFFFFC00);
      pc    = pc | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
      fpc   = ($urandom_range(0, 2) == 0) ? pc : (32'($urandom_range(0, 255)) << 2);

      mDecide(f3, eq, lt, ok, tk);
      eTk = v && ok && tk;
      eMp = v && ok && (eTk != pt);

      rst = doRst;
      drive(v, pc, f3, pt, tgt, eq, lt, fpc);
      #1;
      chk($sformatf("rnd%0d ex_taken", n),    32'(bus.ex_taken),         32'(eTk));
      chk($sformatf("rnd%0d mispredict", n),  32'(bus.mispredict),       32'(eMp));
      chk($sformatf("rnd%0d fetch_pred", n),  32'(bus.fetch_pred_taken), 32'(mCtr[mIdx(fpc)] >= 2));
      chk($sformatf("rnd%0d BrUn", n),        32'(bus.BrUn),             32'(f3 == 3'd6 || f3 == 3'd7 || f3 == 3'd2 || f3 == 3'd3));
      chk($sformatf("rnd%0d redirect_pc", n), bus.redirect_pc,           eTk ? tgt : pc + 32'd4);
      chk($sformatf("rnd%0d br_count", n),    bus.br_count,              mBr);
      chk($sformatf("rnd%0d mp_count", n),    bus.mp_count,              mMp);
      tick();

      if (doRst) begin
        mReset();
      end else if (v && ok) begin
        k = mIdx(pc);
        if (eTk) mCtr[k] = (mCtr[k] == 3) ? 3 : mCtr[k] + 1;
        else     mCtr[k] = (mCtr[k] == 0) ? 0 : mCtr[k] - 1;
        mBr = mBr + 1;
        if (eMp) mMp = mMp + 1;
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
